// File: rtl/blastn_ctrl_pkg.sv
// Shared control definitions for the Blastn array drain path: FSM encoding,
// default array geometry and the nucleotide codes used across the array.
package blastn_ctrl_pkg;

    localparam int NUM_UNITS_DEF      = 4;
    localparam int LENGTH_COUNTER_DEF = 8;

    localparam logic [2:0] NT_A = 3'b001;
    localparam logic [2:0] NT_G = 3'b010;
    localparam logic [2:0] NT_T = 3'b011;
    localparam logic [2:0] NT_C = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUTPUT  = 3'd4
    } drain_state_t;

endpackage

// File: rtl/hsp_drain_arbiter_rr_grant.sv
// Round-robin priority search: picks the first requester at or above rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; result is a function of the current inputs only.
module rr_grant
    import blastn_ctrl_pkg::*;
#(
    parameter int NUM_UNITS = NUM_UNITS_DEF,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_UNITS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = NUM_UNITS - 1; off >= 0; off--) begin
            cand = int'(rr_ptr) + off;
            if (cand >= NUM_UNITS) begin
                cand = cand - NUM_UNITS;
            end
            if (req[IDX_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/hsp_drain_arbiter.sv
// Drains NUM_UNITS Blastn_Unit summary FIFOs round-robin into one tagged record stream (HSP_FILTER_EN drops short hits).
// Latency: strobe 1 cycle after a non-empty unit is seen in IDLE, out_valid 4 cycles after; 5 cycles per record minimum.
// Backpressure: single-entry output held stable until out_ready; no unit is strobed while a record is held.
module hsp_drain_arbiter
    import blastn_ctrl_pkg::*;
#(
    parameter int NUM_UNITS      = NUM_UNITS_DEF,
    parameter int IDX_W          = 2,
    parameter int LENGTH_COUNTER = LENGTH_COUNTER_DEF,
    parameter int MIN_HIT_LENGTH = 4
) (
    input  logic                                array_clk,
    input  logic                                reset,
    input  logic [NUM_UNITS-1:0]                unit_empty,
    output logic [NUM_UNITS-1:0]                unit_read_HSP,
    input  logic [NUM_UNITS*LENGTH_COUNTER-1:0] unit_hit_inQ,
    input  logic [NUM_UNITS*LENGTH_COUNTER-1:0] unit_hit_inS,
    input  logic [NUM_UNITS*LENGTH_COUNTER-1:0] unit_hit_len,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [IDX_W-1:0]                    out_unit,
    output logic [LENGTH_COUNTER-1:0]           out_hit_inQ,
    output logic [LENGTH_COUNTER-1:0]           out_hit_inS,
    output logic [LENGTH_COUNTER-1:0]           out_hit_len,
    output logic [15:0]                         hsp_count,
    output logic                                busy
`ifdef HSP_FILTER_EN
    ,
    output logic [15:0]                         drop_count
`endif
);

    if (IDX_W != $clog2(NUM_UNITS) || MIN_HIT_LENGTH < 1) begin : g_bad_cfg
        $error("hsp_drain_arbiter: IDX_W must equal clog2(NUM_UNITS) and MIN_HIT_LENGTH must be >= 1");
    end

    typedef struct packed {
        logic [LENGTH_COUNTER-1:0] q;
        logic [LENGTH_COUNTER-1:0] s;
        logic [LENGTH_COUNTER-1:0] len;
    } hit_rec_t;

    drain_state_t     state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] next_ptr;
    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;
    hit_rec_t         cap_rec;
    hit_rec_t         out_rec;

    rr_grant #(
        .NUM_UNITS (NUM_UNITS),
        .IDX_W     (IDX_W)
    ) u_rr_grant (
        .req         (~unit_empty),
        .rr_ptr      (rr_ptr),
        .grant_valid (sel_vld),
        .grant_idx   (sel_idx)
    );

    always_comb begin
        cap_rec.q   = unit_hit_inQ[int'(grant_idx)*LENGTH_COUNTER +: LENGTH_COUNTER];
        cap_rec.s   = unit_hit_inS[int'(grant_idx)*LENGTH_COUNTER +: LENGTH_COUNTER];
        cap_rec.len = unit_hit_len[int'(grant_idx)*LENGTH_COUNTER +: LENGTH_COUNTER];
    end

    assign next_ptr = (grant_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;

    // The strobe re-checks the live empty flag so a unit drained since the
    // grant is never popped; this is the only output not taken from a flop.
    always_comb begin
        unit_read_HSP = '0;
        if (state == ST_READ && !unit_empty[grant_idx]) begin
            unit_read_HSP[grant_idx] = 1'b1;
        end
    end

    assign out_hit_inQ = out_rec.q;
    assign out_hit_inS = out_rec.s;
    assign out_hit_len = out_rec.len;

    always_ff @(posedge array_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            out_valid <= 1'b0;
            out_unit  <= '0;
            out_rec   <= '0;
            hsp_count <= '0;
            busy      <= 1'b0;
`ifdef HSP_FILTER_EN
            drop_count <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_vld) begin
                        grant_idx <= sel_idx;
                        state     <= ST_READ;
                        busy      <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (unit_empty[grant_idx]) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rr_ptr <= next_ptr;
`ifdef HSP_FILTER_EN
                    if (int'(cap_rec.len) < MIN_HIT_LENGTH - 1) begin
                        if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        out_rec   <= cap_rec;
                        out_unit  <= grant_idx;
                        out_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end
`else
                    out_rec   <= cap_rec;
                    out_unit  <= grant_idx;
                    out_valid <= 1'b1;
                    state     <= ST_OUTPUT;
`endif
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (hsp_count != 16'hFFFF) begin
                            hsp_count <= hsp_count + 16'd1;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsp_drain_arbiter.sv
// Scoreboard bench for hsp_drain_arbiter: per-unit FIFO models feed the DUT,
// expected records are queued at load time and compared on each output handshake.
module tb_hsp_drain_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  unit_empty;
    logic [3:0]  unit_read_HSP;
    logic [31:0] unit_hit_inQ;
    logic [31:0] unit_hit_inS;
    logic [31:0] unit_hit_len;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_unit;
    logic [7:0]  out_hit_inQ;
    logic [7:0]  out_hit_inS;
    logic [7:0]  out_hit_len;
    logic [15:0] hsp_count;
    logic        busy;
`ifdef HSP_FILTER_EN
    logic [15:0] drop_count;
`endif

    hsp_drain_arbiter dut (
        .array_clk     (clk),
        .reset         (reset),
        .unit_empty    (unit_empty),
        .unit_read_HSP (unit_read_HSP),
        .unit_hit_inQ  (unit_hit_inQ),
        .unit_hit_inS  (unit_hit_inS),
        .unit_hit_len  (unit_hit_len),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_unit      (out_unit),
        .out_hit_inQ   (out_hit_inQ),
        .out_hit_inS   (out_hit_inS),
        .out_hit_len   (out_hit_len),
        .hsp_count     (hsp_count),
        .busy          (busy)
`ifdef HSP_FILTER_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [23:0] fq [4][$];
    logic [31:0] exp_q [$];
    logic [3:0]  force_empty;

    logic [3:0]  s_stb;
    logic        s_ov;
    logic        s_busy;
    logic [1:0]  s_unit;
    logic [23:0] s_rec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mk(input int u, input logic [7:0] q, input logic [7:0] s, input logic [7:0] l);
        return {6'b0, 2'(u), q, s, l};
    endfunction

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            unit_empty[i] = (fq[i].size() == 0) || force_empty[i];
        end
    endtask

    task automatic push_rec(input int u, input logic [7:0] q, input logic [7:0] s,
                            input logic [7:0] l, input bit expect_out);
        fq[u].push_back({q, s, l});
        if (expect_out) exp_q.push_back(mk(u, q, s, l));
        refresh();
    endtask

    // One cycle: sample at negedge, then update the FIFO models just after posedge.
    task automatic step();
        logic [3:0]  stb;
        logic [23:0] r;
        @(negedge clk);
        stb    = unit_read_HSP;
        s_stb  = unit_read_HSP;
        s_ov   = out_valid;
        s_busy = busy;
        s_unit = out_unit;
        s_rec  = {out_hit_inQ, out_hit_inS, out_hit_len};
        if (stb != 4'b0) chk("strobe_onehot", 32'($countones(stb)), 32'd1);
        if (s_ov) chk("strobe_while_valid", 32'(stb), 32'd0);
        if (s_ov && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
            else chk("out_rec", {6'b0, s_unit, s_rec}, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (stb[i]) begin
                if (fq[i].size() == 0) begin
                    chk("strobe_on_empty", 32'(stb), 32'd0);
                end else begin
                    r = fq[i].pop_front();
                    unit_hit_inQ[i*8 +: 8] = r[23:16];
                    unit_hit_inS[i*8 +: 8] = r[15:8];
                    unit_hit_len[i*8 +: 8] = r[7:0];
                end
            end
        end
        refresh();
    endtask

    task automatic run_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset        = 1'b1;
        out_ready    = 1'b1;
        force_empty  = 4'b0;
        unit_hit_inQ = '0;
        unit_hit_inS = '0;
        unit_hit_len = '0;
        refresh();
        step();
        step();
        chk("rst_strobe", 32'(unit_read_HSP), 32'd0);
        chk("rst_valid_busy", {30'b0, out_valid, busy}, 32'd0);
        chk("rst_unit", 32'(out_unit), 32'd0);
        chk("rst_fields", {8'b0, out_hit_inQ, out_hit_inS, out_hit_len}, 32'd0);
        chk("rst_count", 32'(hsp_count), 32'd0);
        reset = 1'b0;

        // Single record from unit 2: strobe at +1, out_valid at +4.
        push_rec(2, 8'h21, 8'h05, 8'h07, 1'b1);
        step(); chk("lat_idle_stb", 32'(s_stb), 32'd0);
        step(); chk("lat_strobe", 32'(s_stb), 32'h4);
        step(); chk("lat_wait_stb", 32'(s_stb), 32'd0);
        step(); chk("lat_cap_valid", 32'(s_ov), 32'd0);
        step(); chk("lat_out_valid", 32'(s_ov), 32'd1);
        chk("lat_out_unit", 32'(s_unit), 32'd2);
        step(); chk("lat_hsp_count", 32'(hsp_count), 32'd1);
        chk("lat_idle_busy", 32'(s_busy), 32'd0);

        // Fairness from a fresh pointer: 0,1,2,3,0,1,2,3.
        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int u = 0; u < 4; u++) begin
                push_rec(u, 8'(16*u + k), 8'(8'hA0 + 4*u + k), 8'(3 + u + k), 1'b1);
            end
        end
        run_drain(100);
        chk("fair_count", 32'(hsp_count), 32'd8);

        // Backpressure: hold the first record for 10 cycles, then release.
        out_ready = 1'b0;
        push_rec(1, 8'h5A, 8'hC3, 8'h09, 1'b1);
        push_rec(3, 8'h3C, 8'h96, 8'h0F, 1'b1);
        n = 0;
        s_ov = 1'b0;
        while (!s_ov && n < 20) begin step(); n++; end
        chk("bp_reach_valid", 32'(s_ov), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold", {6'b0, s_unit, s_rec}, mk(1, 8'h5A, 8'hC3, 8'h09));
        end
        chk("bp_count_stalled", 32'(hsp_count), 32'd8);
        out_ready = 1'b1;
        run_drain(50);
        chk("bp_count", 32'(hsp_count), 32'd10);

        // Unit 1 empties between grant and READ: no strobe, pointer unchanged.
        push_rec(1, 8'h77, 8'h88, 8'h0A, 1'b0);
        step();
        force_empty[1] = 1'b1;
        refresh();
        step();
        chk("abort_no_strobe", 32'(s_stb), 32'd0);
        chk("abort_busy_read", 32'(s_busy), 32'd1);
        step();
        chk("abort_idle", {30'b0, s_busy, s_ov}, 32'd0);
        step(); step();
        chk("abort_stays_idle", {28'b0, s_stb}, 32'd0);
        force_empty[1] = 1'b0;
        exp_q.push_back(mk(0, 8'h11, 8'h22, 8'h05));
        exp_q.push_back(mk(1, 8'h77, 8'h88, 8'h0A));
        push_rec(0, 8'h11, 8'h22, 8'h05, 1'b0);
        run_drain(50);
        chk("abort_count", 32'(hsp_count), 32'd12);

        // Reset while in WAIT abandons the record; unit 0 wins afterwards.
        push_rec(3, 8'hE1, 8'hE2, 8'h04, 1'b0);
        step();
        step(); chk("rstw_strobe", 32'(s_stb), 32'h8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstw_outs", {18'b0, unit_read_HSP, out_valid, busy, out_unit, 6'b0}, 32'd0);
        chk("rstw_fields", {8'b0, out_hit_inQ, out_hit_inS, out_hit_len}, 32'd0);
        chk("rstw_count", 32'(hsp_count), 32'd0);
        push_rec(3, 8'hD3, 8'hD4, 8'h06, 1'b0);
        push_rec(0, 8'hB0, 8'hB1, 8'h08, 1'b0);
        exp_q.push_back(mk(0, 8'hB0, 8'hB1, 8'h08));
        exp_q.push_back(mk(3, 8'hD3, 8'hD4, 8'h06));
        run_drain(50);
        chk("rstw_after_count", 32'(hsp_count), 32'd2);

`ifdef HSP_FILTER_EN
        push_rec(1, 8'h40, 8'h41, 8'h02, 1'b0);
        push_rec(1, 8'h50, 8'h51, 8'h05, 1'b1);
        run_drain(60);
        chk("filt_drop_count", 32'(drop_count), 32'd1);
        chk("filt_hsp_count", 32'(hsp_count), 32'd3);
`endif

        for (int i = 0; i < 6; i++) step();
        chk("final_idle", {30'b0, busy, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hsp_drain_arbiter.md
Name: hsp_drain_arbiter

Overview:
- Drains hit records from NUM_UNITS Blastn_Unit summary FIFOs into one tagged output stream.
- Arbitration is round-robin over the non-empty units. The block issues a one-cycle read_HSP strobe to the granted unit, captures its record, and presents it on a valid/ready interface.
- Sits between the Blastn_Unit array and the ungapped-extension / host-transfer path.

Parameters:
- NUM_UNITS, 4, number of Blastn_Unit requesters.
- IDX_W, 2, width of the unit index; must equal clog2(NUM_UNITS).
- LENGTH_COUNTER, 8, width of each hit field (Q address, S address, length).
- MIN_HIT_LENGTH, 4, filter threshold; used only when HSP_FILTER_EN is defined.

Ports:
- array_clk  in  1  the single clock.
- reset  in  1  synchronous, active-high reset.
- unit_empty  in  NUM_UNITS  per-unit summary-FIFO empty flag.
- unit_read_HSP  out  NUM_UNITS  one-hot, single-cycle read strobe to the granted unit.
- unit_hit_inQ  in  NUM_UNITS*LENGTH_COUNTER  packed Q addresses; unit i occupies slice [i*8 +: 8].
- unit_hit_inS  in  NUM_UNITS*LENGTH_COUNTER  packed S addresses.
- unit_hit_len  in  NUM_UNITS*LENGTH_COUNTER  packed hit lengths (stored value is length-1).
- out_valid  out  1  output record valid.
- out_ready  in  1  downstream accept.
- out_unit  out  IDX_W  source unit index.
- out_hit_inQ, out_hit_inS, out_hit_len  out  LENGTH_COUNTER each  captured record.
- hsp_count  out  16  total records delivered; saturates at 16'hFFFF.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, at the next array_clk edge with reset=1:
  - FSM goes to IDLE; rr_ptr=0.
  - All outputs go to 0: unit_read_HSP, out_valid, out_unit, out data, hsp_count, busy.
  - Reset mid-transaction abandons the in-flight record. A strobe already issued is not reissued.
- FSM states and transitions:
  - IDLE:
    - If any unit_empty bit is 0, grant the first non-empty unit searching upward from rr_ptr with wrap-around.
    - Register grant_idx, then go to READ.
    - If all units are empty, stay in IDLE.
  - READ:
    - unit_read_HSP[grant_idx]=1 for exactly this cycle, then go to WAIT.
    - Re-check unit_empty[grant_idx] before strobing. If it is 1 (emptied since grant), issue no strobe and return to IDLE; rr_ptr is unchanged.
  - WAIT: Fifo_B data is valid one cycle after the strobe. Go to CAPTURE.
  - CAPTURE:
    - Latch the three fields from slice grant_idx and set out_unit=grant_idx.
    - Assert out_valid next cycle and go to OUTPUT.
    - Set rr_ptr=grant_idx+1, modulo NUM_UNITS.
  - OUTPUT:
    - Hold out_valid and all out_* fields stable until out_ready=1.
    - On the handshake cycle (out_valid & out_ready): clear out_valid, increment hsp_count (saturating), go to IDLE.
- Latency:
  - A non-empty unit in IDLE gives strobe at +1, data captured at +3, out_valid at +4.
  - Minimum of 5 cycles per record with out_ready tied high.
- Fairness:
  - With all units continuously non-empty, grants rotate 0,1,2,3,0.
  - No unit waits more than NUM_UNITS grants.
- Strobe rules:
  - At most one unit_read_HSP bit is high in any cycle.
  - No strobe is issued while out_valid is high (single-entry buffer; no overrun).
- out_ready high while out_valid is low is ignored.
- unit_empty changes on non-granted units during a transaction are ignored until the next IDLE.
- Arithmetic: hsp_count is an unsigned 16-bit saturating counter. Fields pass through unmodified.

Optional Feature:
- Macro: HSP_FILTER_EN.
- Defined:
  - In CAPTURE, a record with unit_hit_len slice < MIN_HIT_LENGTH-1 is dropped: out_valid is not asserted, rr_ptr still advances, FSM returns to IDLE.
  - Adds output port drop_count [15:0], saturating, reset to 0, incremented per dropped record.
  - hsp_count counts delivered records only.
- Not defined: every record is forwarded; no drop_count port; MIN_HIT_LENGTH is unused.

Decomposition:
- Package blastn_ctrl_pkg holds:
  - the FSM state encoding (IDLE, READ, WAIT, CAPTURE, OUTPUT);
  - the LENGTH_COUNTER and NUM_UNITS defaults;
  - the nucleotide codes A=3'b001, G=3'b010, T=3'b011, C=3'b100, shared with the array.
- One natural sub-module, rr_grant: a combinational round-robin priority search taking (req vector, rr_ptr) and returning (grant_valid, grant_idx).

Test Plan:
- Only unit 2 non-empty with Q=8'h21, S=8'h05, len=8'h07; out_ready=1 → unit_read_HSP=4'b0100 for 1 cycle at +1; out_valid at +4 with out_unit=2, Q=21, S=05, len=07; hsp_count=1.
- All four units non-empty, out_ready=1, 8 records → out_unit sequence 0,1,2,3,0,1,2,3; never two strobe bits high.
- out_ready=0 for 10 cycles after out_valid → fields stable and no further strobes; raise out_ready → one handshake, then the next grant proceeds.
- unit 1 empty flag rises between IDLE grant and READ → no strobe, return to IDLE; rr_ptr unchanged; no output.
- reset asserted during WAIT → next cycle all outputs 0 and FSM in IDLE; after reset, unit 0 is granted first.
- HSP_FILTER_EN defined, MIN_HIT_LENGTH=4: records with len=8'h02 then 8'h05 → first dropped (drop_count=1), second delivered (hsp_count=1).
